// File: rtl/aes_pkg.sv
// Shared AES key-schedule helpers: S-box, SubWord, RotWord, Rcon and FSM state type.
// Byte 0 of a word sits in bits [7:0].
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 and 11..15 are never selected for legal key lengths.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

endpackage

// File: rtl/aes_key_sched_word.sv
// Combinational next schedule word from the previous word, the word Nk back,
// the position within the key period and the round number.
module aes_key_sched_word
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4
) (
  input  logic [31:0] prev_word,
  input  logic [31:0] back_word,
  input  logic [2:0]  idx_mod,
  input  logic [3:0]  rnd,
  output logic [31:0] next_word_c
);

  logic [31:0] temp;

  always_comb begin
    temp = prev_word;
    if (idx_mod == 3'd0) begin
      temp = sub_word(rot_word(prev_word)) ^ {24'h000000, RCON[rnd]};
    end else if ((Nk == 8) && (idx_mod == 3'd4)) begin
      temp = sub_word(prev_word);
    end
    next_word_c = back_word ^ temp;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one word per clock, full schedule held with rkey_valid.
// Optional AES_KEYEXP_ZEROIZE_EN clears stale schedule words when a new key loads.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter  int unsigned Nk = 4,
  parameter  int unsigned Nr = Nk + 6,
  localparam int unsigned NW = 4 * (Nr + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [32*Nk-1:0] key,
  output logic             key_ready,
  output logic [31:0]      rkey [NW],
  output logic             rkey_valid
);

  localparam int unsigned IW = $clog2(NW + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    mod_q, mod_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          key_ready_q, key_ready_d;
  logic          rkey_valid_q, rkey_valid_d;
  logic [31:0]   rkey_q [NW];
  logic [31:0]   rkey_d [NW];
  logic [IW-1:0] prev_idx, back_idx;
  logic [31:0]   next_word_c;

  assign prev_idx = idx_q - IW'(1);
  assign back_idx = idx_q - IW'(Nk);

  aes_key_sched_word #(.Nk(Nk)) u_word (
    .prev_word   (rkey_q[prev_idx]),
    .back_word   (rkey_q[back_idx]),
    .idx_mod     (mod_q),
    .rnd         (rnd_q),
    .next_word_c (next_word_c)
  );

  // Next-state, counters and word-array writes.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mod_d        = mod_q;
    rnd_d        = rnd_q;
    key_ready_d  = key_ready_q;
    rkey_valid_d = rkey_valid_q;
    rkey_d       = rkey_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_valid) begin
          for (int unsigned j = 0; j < Nk; j++) rkey_d[j] = key[32*j +: 32];
`ifdef AES_KEYEXP_ZEROIZE_EN
          for (int unsigned j = Nk; j < NW; j++) rkey_d[j] = '0;
`endif
          idx_d        = IW'(Nk);
          mod_d        = 3'd0;
          rnd_d        = 4'd1;
          key_ready_d  = 1'b0;
          rkey_valid_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        rkey_d[idx_q] = next_word_c;
        idx_d         = idx_q + IW'(1);
        if (mod_q == 3'(Nk - 1)) begin
          mod_d = 3'd0;
          rnd_d = rnd_q + 4'd1;
        end else begin
          mod_d = mod_q + 3'd1;
        end
        if (idx_q == IW'(NW - 1)) begin
          state_d      = ST_DONE;
          key_ready_d  = 1'b1;
          rkey_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      mod_q        <= '0;
      rnd_q        <= '0;
      key_ready_q  <= 1'b1;
      rkey_valid_q <= 1'b0;
      rkey_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mod_q        <= mod_d;
      rnd_q        <= rnd_d;
      key_ready_q  <= key_ready_d;
      rkey_valid_q <= rkey_valid_d;
      rkey_q       <= rkey_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign rkey_valid = rkey_valid_q;
  assign rkey       = rkey_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand at Nk=4/6/8 against a byte-level FIPS-197 model
// whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         kv4, kv6, kv8;
  logic [127:0] k4;
  logic [191:0] k6;
  logic [255:0] k8;
  logic         rdy4, rdy6, rdy8;
  logic         val4, val6, val8;
  logic [31:0]  rk4 [44];
  logic [31:0]  rk6 [52];
  logic [31:0]  rk8 [60];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbox_ref [256];

  aes_key_expand #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .key_valid(kv4), .key(k4),
                                 .key_ready(rdy4), .rkey(rk4), .rkey_valid(val4));
  aes_key_expand #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .key_valid(kv6), .key(k6),
                                 .key_ready(rdy6), .rkey(rk6), .rkey_valid(val6));
  aes_key_expand #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .key_valid(kv8), .key(k8),
                                 .key_ready(rdy8), .rkey(rk8), .rkey_valid(val8));

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion on byte arrays; result packed with byte 0 in bits [7:0].
  task automatic ref_schedule(input int nk, input logic [7:0] kb [32], output logic [31:0] w [60]);
    logic [7:0] wb [60][4];
    logic [7:0] t [4];
    logic [7:0] tmp;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 60; i++) for (int b = 0; b < 4; b++) wb[i][b] = 8'h00;
    for (int i = 0; i < nk; i++) for (int b = 0; b < 4; b++) wb[i][b] = kb[4*i+b];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      for (int b = 0; b < 4; b++) t[b] = wb[i-1][b];
      if (i % nk == 0) begin
        tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
        for (int b = 0; b < 4; b++) t[b] = sbox_ref[t[b]];
        t[0] = t[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sbox_ref[t[b]];
      end
      for (int b = 0; b < 4; b++) wb[i][b] = wb[i-nk][b] ^ t[b];
    end
    for (int i = 0; i < 60; i++) w[i] = {wb[i][3], wb[i][2], wb[i][1], wb[i][0]};
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] f);
    return {f[7:0], f[15:8], f[23:16], f[31:24]};
  endfunction

  task automatic fips_key(input logic [31:0] fw [8], output logic [7:0] kb [32]);
    for (int j = 0; j < 8; j++)
      for (int b = 0; b < 4; b++) kb[4*j+b] = fw[j][31-8*b -: 8];
  endtask

  task automatic rand_key(output logic [7:0] kb [32]);
    for (int i = 0; i < 32; i++) kb[i] = 8'($urandom);
  endtask

  function automatic logic [31:0] dut_word(input int nk, input int i);
    case (nk)
      4:       return rk4[6'(i)];
      6:       return rk6[6'(i)];
      default: return rk8[6'(i)];
    endcase
  endfunction

  function automatic logic dut_valid(input int nk);
    return (nk == 4) ? val4 : (nk == 6) ? val6 : val8;
  endfunction

  function automatic logic dut_ready(input int nk);
    return (nk == 4) ? rdy4 : (nk == 6) ? rdy6 : rdy8;
  endfunction

  function automatic int nonzero_words(input int nk, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (dut_word(nk, i) !== 32'h0) n++;
    return n;
  endfunction

  task automatic drive(input int nk, input logic [7:0] kb [32], input logic v);
    logic [255:0] bits;
    for (int i = 0; i < 32; i++) bits[8*i +: 8] = kb[i];
    case (nk)
      4:       begin k4 = bits[127:0]; kv4 = v; end
      6:       begin k6 = bits[191:0]; kv6 = v; end
      default: begin k8 = bits;        kv8 = v; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for rkey_valid; n counts edges with the accepting edge as 1.
  task automatic wait_valid(input int nk, input int n_start, input string tag);
    int n = n_start;
    int ready_hi = 0;
    while (!dut_valid(nk) && n < 200) begin
      if (dut_ready(nk)) ready_hi++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(4 * (nk + 7) - nk + 1));
    check({tag, " ready low in expand"}, 32'(ready_hi), 32'd0);
  endtask

  task automatic run_key(input int nk, input logic [7:0] kb [32], input string tag);
    drive(nk, kb, 1'b1);
    @(posedge clk); #1;
    drive(nk, kb, 1'b0);
    check({tag, " valid drops after accept"}, 32'(dut_valid(nk)), 32'd0);
`ifdef AES_KEYEXP_ZEROIZE_EN
    check({tag, " zeroized tail"}, 32'(nonzero_words(nk, nk, 4 * (nk + 7) - 1)), 32'd0);
`endif
    wait_valid(nk, 1, tag);
  endtask

  task automatic cmp_sched(input int nk, input logic [7:0] kb [32], input string tag);
    logic [31:0] w [60];
    ref_schedule(nk, kb, w);
    for (int i = 0; i < 4 * (nk + 7); i++)
      check($sformatf("%s w%0d", tag, i), dut_word(nk, i), w[i]);
  endtask

  initial begin
    logic [31:0] fw [8];
    logic [7:0]  ka [32];
    logic [7:0]  kb [32];
    int          nks [3] = '{4, 6, 8};

    rst = 1'b1;
    kv4 = 1'b0; kv6 = 1'b0; kv8 = 1'b0;
    k4 = '0; k6 = '0; k8 = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    foreach (nks[i]) begin
      check($sformatf("reset valid nk%0d", nks[i]), 32'(dut_valid(nks[i])), 32'd0);
      check($sformatf("reset ready nk%0d", nks[i]), 32'(dut_ready(nks[i])), 32'd1);
      check($sformatf("reset words nk%0d", nks[i]), 32'(nonzero_words(nks[i], 0, 4 * (nks[i] + 7) - 1)), 32'd0);
    end

    fw = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 32'h0, 32'h0, 32'h0, 32'h0};
    fips_key(fw, ka);
    run_key(4, ka, "aes128");
    check("aes128 w4", dut_word(4, 4), bswap(32'ha0fafe17));
    check("aes128 w43", dut_word(4, 43), bswap(32'hb6630ca6));
    cmp_sched(4, ka, "aes128");

    fw = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
           32'h62f8ead2, 32'h522c6b7b, 32'h0, 32'h0};
    fips_key(fw, ka);
    run_key(6, ka, "aes192");
    check("aes192 w51", dut_word(6, 51), bswap(32'h01002202));
    cmp_sched(6, ka, "aes192");

    fw = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
           32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    fips_key(fw, ka);
    run_key(8, ka, "aes256");
    check("aes256 w12", dut_word(8, 12), bswap(32'ha8b09c1a));
    check("aes256 w59", dut_word(8, 59), bswap(32'h706c631e));
    cmp_sched(8, ka, "aes256");

    // A second key offered mid-expansion must be dropped.
    rand_key(ka);
    rand_key(kb);
    drive(4, ka, 1'b1);
    @(posedge clk); #1;
    drive(4, kb, 1'b1);
    repeat (3) @(posedge clk);
    #1 drive(4, kb, 1'b0);
    wait_valid(4, 4, "ignore");
    cmp_sched(4, ka, "ignore");

    run_key(4, kb, "rekey");
    cmp_sched(4, kb, "rekey");

    // Reset while the engine is about to write word 20.
    rand_key(ka);
    drive(4, ka, 1'b1);
    @(posedge clk); #1;
    drive(4, ka, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    check("midrst valid before reset", 32'(val4), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst valid", 32'(val4), 32'd0);
    check("midrst ready", 32'(rdy4), 32'd1);
    check("midrst words", 32'(nonzero_words(4, 0, 43)), 32'd0);
    run_key(4, ka, "midrst");
    cmp_sched(4, ka, "midrst");

    for (int r = 0; r < 2; r++) begin
      foreach (nks[i]) begin
        rand_key(ka);
        run_key(nks[i], ka, $sformatf("rand%0d nk%0d", r, nks[i]));
        cmp_sched(nks[i], ka, $sformatf("rand%0d nk%0d", r, nks[i]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
